// File: rtl/ama_riscv_wb_stage.sv
// Writeback stage: selects the register-file write source, waits for and aligns load data.
// Define AMA_RISCV_WB_INSTRET_EN to add the 64-bit retired-instruction counter and port.
module ama_riscv_wb_stage #(
  parameter int unsigned LOAD_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_rf_we,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_csr,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_data,
  output logic        rf_we,
  output logic [4:0]  rf_addr_d,
  output logic [31:0] rf_data_d,
  output logic        retire,
`ifdef AMA_RISCV_WB_INSTRET_EN
  output logic [63:0] instret,
`endif
  output logic        load_err
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [7:0]  wait_cnt_q;
  logic        rf_we_q;
  logic [4:0]  rf_addr_q;
  logic [31:0] rf_data_q;
  logic        retire_q;
  logic        load_err_q;

  logic        accept;
  logic        complete;
  logic [31:0] src_data;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign in_ready = (state_q == StIdle) && rst;
  assign accept   = in_valid && in_ready;
  // Any edge that will raise retire: a non-load accept or a load response.
  assign complete = (accept && (in_wb_sel != 2'd1)) || ((state_q == StWait) && dmem_rsp_valid);

  always_comb begin
    src_data = in_alu;
    case (in_wb_sel)
      2'd2:    src_data = in_pc + 32'd4;
      2'd3:    src_data = in_csr;
      default: src_data = in_alu;
    endcase
  end

  always_comb begin
    ld_byte = dmem_rsp_data[7:0];
    case (addr_lo_q)
      2'd1:    ld_byte = dmem_rsp_data[15:8];
      2'd2:    ld_byte = dmem_rsp_data[23:16];
      2'd3:    ld_byte = dmem_rsp_data[31:24];
      default: ld_byte = dmem_rsp_data[7:0];
    endcase
    ld_half = addr_lo_q[1] ? dmem_rsp_data[31:16] : dmem_rsp_data[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rsp_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      rd_q       <= 5'd0;
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
      addr_lo_q  <= 2'd0;
      wait_cnt_q <= 8'd0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= 5'd0;
      rf_data_q  <= 32'd0;
      retire_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      rf_we_q  <= 1'b0;
      retire_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (in_wb_sel == 2'd1) begin
              state_q    <= StWait;
              rd_q       <= in_rd;
              we_q       <= in_rf_we;
              funct3_q   <= in_funct3;
              addr_lo_q  <= in_addr_lo;
              wait_cnt_q <= 8'd0;
            end else begin
              rf_we_q   <= in_rf_we && (in_rd != 5'd0);
              rf_addr_q <= in_rd;
              rf_data_q <= src_data;
              retire_q  <= 1'b1;
            end
          end
        end
        StWait: begin
          // A response on the last allowed cycle wins over the timeout.
          if (dmem_rsp_valid) begin
            state_q   <= StIdle;
            rf_we_q   <= we_q && (rd_q != 5'd0);
            rf_addr_q <= rd_q;
            rf_data_q <= ld_data;
            retire_q  <= 1'b1;
          end else if (wait_cnt_q == 8'(LOAD_WAIT_MAX - 1)) begin
            state_q    <= StIdle;
            load_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_addr_d = rf_addr_q;
  assign rf_data_d = rf_data_q;
  assign retire    = retire_q;
  assign load_err  = load_err_q;

`ifdef AMA_RISCV_WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= 64'd0;
    end else if (complete) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_ama_riscv_wb_stage.sv
// Directed self-checking bench for ama_riscv_wb_stage (LOAD_WAIT_MAX = 4).
module tb_ama_riscv_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rf_we;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu;
  logic [31:0] in_pc;
  logic [31:0] in_csr;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_data;
  logic        rf_we;
  logic [4:0]  rf_addr_d;
  logic [31:0] rf_data_d;
  logic        retire;
  logic        load_err;
`ifdef AMA_RISCV_WB_INSTRET_EN
  logic [63:0] instret;
`endif

  int checks;
  int failures;

  ama_riscv_wb_stage #(.LOAD_WAIT_MAX(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rd          (in_rd),
    .in_rf_we       (in_rf_we),
    .in_wb_sel      (in_wb_sel),
    .in_alu         (in_alu),
    .in_pc          (in_pc),
    .in_csr         (in_csr),
    .in_funct3      (in_funct3),
    .in_addr_lo     (in_addr_lo),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_data  (dmem_rsp_data),
    .rf_we          (rf_we),
    .rf_addr_d      (rf_addr_d),
    .rf_data_d      (rf_data_d),
    .retire         (retire),
`ifdef AMA_RISCV_WB_INSTRET_EN
    .instret        (instret),
`endif
    .load_err       (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [1:0] lo);
    in_valid   = 1'b1;
    in_rd      = rd;
    in_rf_we   = we;
    in_wb_sel  = sel;
    in_funct3  = f3;
    in_addr_lo = lo;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0; in_rd = '0; in_rf_we = 1'b0; in_wb_sel = '0;
    in_alu = '0; in_pc = '0; in_csr = '0; in_funct3 = '0; in_addr_lo = '0;
    dmem_rsp_valid = 1'b0; dmem_rsp_data = '0;
    #12;
    checks++;
    if ({in_ready, rf_we, rf_addr_d, rf_data_d, retire, load_err} !== 41'd0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b we=%b addr=%0d data=%h ret=%b err=%b want 0",
               in_ready, rf_we, rf_addr_d, rf_data_d, retire, load_err);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_alu();
    set_op(5'd5, 1'b1, 2'd0, 3'd0, 2'd0);
    in_alu = 32'h12345678;
    step();
    in_valid = 1'b0;
    checks++;
    if ({rf_we, rf_addr_d, rf_data_d, retire} !== {1'b1, 5'd5, 32'h12345678, 1'b1}) begin
      failures++;
      $display("FAIL alu_wb got we=%b addr=%0d data=%h ret=%b want 1 5 12345678 1",
               rf_we, rf_addr_d, rf_data_d, retire);
    end
    step();
    checks++;
    if ({rf_we, retire} !== 2'b00) begin
      failures++;
      $display("FAIL alu_idle_deassert got we=%b ret=%b want 0 0", rf_we, retire);
    end
  endtask

  task automatic test_back_to_back();
    set_op(5'd0, 1'b1, 2'd0, 3'd0, 2'd0);
    in_alu = 32'h11111111;
    step();
    checks++;
    if ({rf_we, retire} !== 2'b01) begin
      failures++;
      $display("FAIL x0_write got we=%b ret=%b want 0 1", rf_we, retire);
    end
    set_op(5'd1, 1'b1, 2'd2, 3'd0, 2'd0);
    in_pc = 32'hFFFFFFFC;
    step();
    checks++;
    if ({rf_we, rf_addr_d, rf_data_d, retire} !== {1'b1, 5'd1, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL pc4_wrap got we=%b addr=%0d data=%h ret=%b want 1 1 00000000 1",
               rf_we, rf_addr_d, rf_data_d, retire);
    end
    set_op(5'd7, 1'b1, 2'd3, 3'd0, 2'd0);
    in_csr = 32'hDEADBEEF;
    step();
    checks++;
    if ({rf_we, rf_addr_d, rf_data_d} !== {1'b1, 5'd7, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL csr_wb got we=%b addr=%0d data=%h want 1 7 deadbeef",
               rf_we, rf_addr_d, rf_data_d);
    end
    set_op(5'd2, 1'b0, 2'd0, 3'd0, 2'd0);
    step();
    in_valid = 1'b0;
    checks++;
    if ({rf_we, retire} !== 2'b01) begin
      failures++;
      $display("FAIL no_we_retire got we=%b ret=%b want 0 1", rf_we, retire);
    end
    step();
  endtask

  task automatic do_load(input string name, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] rsp, input logic [31:0] exp);
    set_op(5'd10, 1'b1, 2'd1, f3, lo);
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_wait_ready got %b want 0", name, in_ready);
    end
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = rsp;
    step();
    dmem_rsp_valid = 1'b0;
    checks++;
    if ({rf_we, rf_addr_d, rf_data_d, retire, in_ready} !== {1'b1, 5'd10, exp, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL %s got we=%b addr=%0d data=%h ret=%b rdy=%b want 1 10 %h 1 1",
               name, rf_we, rf_addr_d, rf_data_d, retire, in_ready, exp);
    end
  endtask

  task automatic test_load_align();
    do_load("lb_off3",   3'b000, 2'd3, 32'h80FF0000, 32'hFFFFFF80);
    do_load("lhu_off2",  3'b101, 2'd2, 32'h8001ABCD, 32'h00008001);
    do_load("lh_off0",   3'b001, 2'd0, 32'h0000F00F, 32'hFFFFF00F);
    do_load("lbu_off1",  3'b100, 2'd1, 32'h0000AB00, 32'h000000AB);
    do_load("lh_off3",   3'b001, 2'd3, 32'h8001ABCD, 32'hFFFF8001);
    do_load("lw",        3'b010, 2'd1, 32'hCAFEF00D, 32'hCAFEF00D);
    do_load("f3_111",    3'b111, 2'd2, 32'h87654321, 32'h87654321);
  endtask

  task automatic test_load_stall();
    // A response presented alongside the accept must not complete the load.
    set_op(5'd3, 1'b1, 2'd1, 3'b010, 2'd0);
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'hBAD0BAD0;
    step();
    dmem_rsp_valid = 1'b0;
    set_op(5'd4, 1'b1, 2'd0, 3'd0, 2'd0);
    in_alu = 32'h00000055;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({in_ready, rf_we, retire} !== 3'b000) begin
        failures++;
        $display("FAIL stall_cycle%0d got rdy=%b we=%b ret=%b want 0 0 0",
                 i, in_ready, rf_we, retire);
      end
      if (i == 2) begin
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = 32'h0A0B0C0D;
      end
      step();
    end
    dmem_rsp_valid = 1'b0;
    checks++;
    if ({rf_we, rf_addr_d, rf_data_d, in_ready} !== {1'b1, 5'd3, 32'h0A0B0C0D, 1'b1}) begin
      failures++;
      $display("FAIL stall_load_wb got we=%b addr=%0d data=%h rdy=%b want 1 3 0a0b0c0d 1",
               rf_we, rf_addr_d, rf_data_d, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({rf_we, rf_addr_d, rf_data_d, retire} !== {1'b1, 5'd4, 32'h55, 1'b1}) begin
      failures++;
      $display("FAIL stall_alu_follow got we=%b addr=%0d data=%h ret=%b want 1 4 00000055 1",
               rf_we, rf_addr_d, rf_data_d, retire);
    end
    step();
  endtask

  task automatic test_timeout();
    // Response on the fourth WAIT cycle still wins.
    set_op(5'd8, 1'b1, 2'd1, 3'b010, 2'd0);
    step();
    in_valid = 1'b0;
    step(); step(); step();
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'h13572468;
    step();
    dmem_rsp_valid = 1'b0;
    checks++;
    if ({rf_we, rf_data_d, load_err} !== {1'b1, 32'h13572468, 1'b0}) begin
      failures++;
      $display("FAIL last_cycle_rsp got we=%b data=%h err=%b want 1 13572468 0",
               rf_we, rf_data_d, load_err);
    end
    set_op(5'd9, 1'b1, 2'd1, 3'b010, 2'd0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({load_err, rf_we, in_ready} !== 3'b000) begin
        failures++;
        $display("FAIL timeout_wait%0d got err=%b we=%b rdy=%b want 0 0 0",
                 i, load_err, rf_we, in_ready);
      end
      step();
    end
    checks++;
    if ({load_err, rf_we, retire, in_ready} !== 4'b1001) begin
      failures++;
      $display("FAIL timeout got err=%b we=%b ret=%b rdy=%b want 1 0 0 1",
               load_err, rf_we, retire, in_ready);
    end
    dmem_rsp_valid = 1'b1;
    step();
    dmem_rsp_valid = 1'b0;
    checks++;
    if ({load_err, rf_we, retire} !== 3'b100) begin
      failures++;
      $display("FAIL late_rsp_ignored got err=%b we=%b ret=%b want 1 0 0",
               load_err, rf_we, retire);
    end
  endtask

  task automatic test_reset_in_wait();
    set_op(5'd6, 1'b1, 2'd1, 3'b010, 2'd0);
    step();
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, rf_we, rf_addr_d, rf_data_d, retire, load_err} !== 41'd0) begin
      failures++;
      $display("FAIL reset_in_wait got rdy=%b we=%b addr=%0d data=%h ret=%b err=%b want 0",
               in_ready, rf_we, rf_addr_d, rf_data_d, retire, load_err);
    end
`ifdef AMA_RISCV_WB_INSTRET_EN
    checks++;
    if (instret !== 64'd0) begin
      failures++;
      $display("FAIL instret_reset got %0d want 0", instret);
    end
`endif
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'hFFFFFFFF;
    step();
    rst = 1'b1;
    step();
    dmem_rsp_valid = 1'b0;
    checks++;
    if ({rf_we, retire, in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL pending_load_discarded got we=%b ret=%b rdy=%b want 0 0 1",
               rf_we, retire, in_ready);
    end
  endtask

`ifdef AMA_RISCV_WB_INSTRET_EN
  task automatic test_instret();
    for (int i = 0; i < 10; i++) begin
      set_op((i == 3 || i == 7) ? 5'd0 : 5'(i + 1), 1'b1, 2'd0, 3'd0, 2'd0);
      in_alu = 32'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (instret !== 64'd10) begin
      failures++;
      $display("FAIL instret_count got %0d want 10", instret);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_align();
    test_load_stall();
    test_timeout();
    test_reset_in_wait();
`ifdef AMA_RISCV_WB_INSTRET_EN
    test_instret();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ama_riscv_wb_stage.md
# ama_riscv_wb_stage

Writeback stage of the AMA-RISCV pipeline: it accepts retiring instructions from the MEM stage and drives the write port of the RV32I register file. It selects the writeback source, and for loads it waits for the data-memory response and aligns and sign-extends the returned word. It also reports retirement and load-timeout errors.

## Interface
- LOAD_WAIT_MAX, 15: maximum cycles spent in WAIT without a memory response before a timeout (range 1..255).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  WB can accept; equals (state==IDLE) and rst high.
- in_rd  in  5  destination register.
- in_rf_we  in  1  instruction writes rd.
- in_wb_sel  in  2  source select: 0 ALU, 1 load, 2 PC+4, 3 CSR.
- in_alu  in  32  ALU result.
- in_pc  in  32  instruction PC.
- in_csr  in  32  CSR read data.
- in_funct3  in  3  load type.
- in_addr_lo  in  2  load byte offset, address bits [1:0].
- dmem_rsp_valid  in  1  load data valid (single-cycle pulse).
- dmem_rsp_data  in  32  load word.
- rf_we  out  1  register-file write enable.
- rf_addr_d  out  5  register-file write address.
- rf_data_d  out  32  register-file write data.
- retire  out  1  one-cycle pulse per completed instruction.
- load_err  out  1  sticky load-timeout flag.
- instret  out  64  retired-instruction count (only when AMA_RISCV_WB_INSTRET_EN is defined).

## Operation
- Accept happens on a rising edge where in_valid && in_ready. All rf_*, retire, load_err and instret outputs are registered.
- States:
  - IDLE: in_ready=1.
  - WAIT: load outstanding, in_ready=0.
- Transitions:
  - IDLE, accept, in_wb_sel≠1: state stays IDLE. rf_* and retire are loaded on the accept edge.
  - IDLE, accept, in_wb_sel=1: state goes to WAIT. rd, rf_we, funct3 and addr_lo are latched and the wait counter clears.
  - WAIT, dmem_rsp_valid=1: state goes to IDLE. rf_* and retire are loaded with the aligned load data.
  - WAIT, wait counter reaches LOAD_WAIT_MAX with no response: state goes to IDLE. load_err is set, with no write and no retire.
- Source data:
  - ALU selects in_alu.
  - PC+4 selects in_pc+32'd4, truncated mod 2^32 (wraps from 0xFFFFFFFC to 0).
  - CSR selects in_csr.
- Load alignment, with w = dmem_rsp_data:
  - LB (000) / LBU (100): byte w[8*addr_lo +: 8], sign-extended for LB, zero-extended for LBU.
  - LH (001) / LHU (101): half w[16*addr_lo[1] +: 16]; addr_lo[0] is ignored.
  - LW (010), and all other funct3 codes: w unmodified.
- x0 protection: rf_we = in_rf_we && (rd≠0). retire still pulses when rf_we=0.
- In IDLE, dmem_rsp_valid is ignored.
- load_err clears only on reset.

## Timing
- Non-load latency: accept at edge N gives rf_we/retire high during cycle N+1. The register file then commits at edge N+1.
- Back-to-back non-loads: one accept per cycle. rf_we may stay high on consecutive cycles.
- Load latency: a response sampled at edge M gives rf_we/retire high during cycle M+1, and in_ready is high again in cycle M+1.
- A response in the same cycle as the load accept is not sampled; the earliest usable response is the cycle after accept.
- Timeout: the counter increments every cycle in WAIT. After LOAD_WAIT_MAX cycles, load_err rises in the next cycle. A response on the final cycle takes priority over the timeout.
- rf_we and retire deassert in any cycle with no completion.
- Reset values: state IDLE, in_ready=0 while rst is low, rf_we=0, rf_addr_d=0, rf_data_d=0, retire=0, load_err=0, instret=0.
- Reset asserted in WAIT discards the pending load, with no write.

## Configuration
- AMA_RISCV_WB_INSTRET_EN defined:
  - 64-bit instret counter and port are present.
  - The counter increments by 1 on the edge that asserts retire, whether or not the retire was an x0 write.
  - The counter wraps from 2^64-1 to 0.
- Not defined: no counter logic and no instret port. All other behaviour is identical.

## Test plan
- ALU writeback: accept in_wb_sel=0, rd=5, in_alu=0x12345678, in_rf_we=1 -> next cycle rf_we=1, rf_addr_d=5, rf_data_d=0x12345678, retire=1.
- x0 and PC+4: accept rd=0, ALU -> rf_we=0, retire=1. Accept rd=1, in_wb_sel=2, in_pc=0xFFFFFFFC -> rf_data_d=0x00000000.
- Load alignment:
  - LB, addr_lo=3, rsp=0x80FF0000 -> rf_data_d=0xFFFFFF80.
  - LHU, addr_lo=2, rsp=0x8001ABCD -> 0x00008001.
  - LH, addr_lo=0, rsp=0x0000F00F -> 0xFFFFF00F.
- Load stall: response 3 cycles after accept, with an ALU op held on in_valid -> in_ready low for 3 cycles, the load writes first, the ALU write follows 1 cycle later.
- Timeout: LOAD_WAIT_MAX=4, no response -> load_err=1 after 4 WAIT cycles, no rf_we, in_ready=1. A later response pulse is ignored.
- Reset and counter: assert rst during WAIT -> no write, all outputs 0. With AMA_RISCV_WB_INSTRET_EN, 10 retires (including 2 x0 writes) -> instret=10.
